// File: rtl/dmux_pkg.sv
// Shared definitions for the 8-way 16-bit mux/demux pair.
//   NUM_WAYS     : number of destination channels
//   SEL_W        : width of a channel index
//   sel_t        : channel index type
//   pipe_state_e : occupancy of the single-word pipeline register
package dmux_pkg;
  localparam int NUM_WAYS = 8;
  localparam int SEL_W    = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pipe_state_e;
endpackage

// File: rtl/dmux8way16_reg_if.sv
// Handshake/bus bundle for dmux8way16_reg.
//   rr_mode, in_valid, in_data, in_sel : upstream word and routing controls
//   in_ready                           : block can take a word this cycle
//   a..h                               : per-destination data outputs
//   out_valid / out_ready              : one-hot pending flags / per-channel ready
//   rr_ptr                             : round-robin pointer (debug)
// master = upstream/downstream environment, slave = the demux.
interface dmux8way16_reg_if #(
  parameter int WIDTH = 16
) ();
  import dmux_pkg::*;

  logic                rr_mode;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  sel_t                in_sel;
  logic [WIDTH-1:0]    a, b, c, d, e, f, g, h;
  logic [NUM_WAYS-1:0] out_valid;
  logic [NUM_WAYS-1:0] out_ready;
  sel_t                rr_ptr;

  modport master (
    output rr_mode, in_valid, in_data, in_sel, out_ready,
    input  in_ready, a, b, c, d, e, f, g, h, out_valid, rr_ptr
  );

  modport slave (
    input  rr_mode, in_valid, in_data, in_sel, out_ready,
    output in_ready, a, b, c, d, e, f, g, h, out_valid, rr_ptr
  );
endinterface

// File: rtl/dmux8way16_comb.sv
// Combinational decode of the held word onto the destination channels.
//   full_i      : pipeline register holds a word
//   hold_sel_i  : destination of the held word
//   hold_data_i : held word
//   out_valid_o : one-hot pending flags
//   data_o      : per-channel data (zeroed when idle if ZERO_IDLE=1)
module dmux8way16_comb
  import dmux_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ZERO_IDLE = 1
) (
  input  logic                           full_i,
  input  sel_t                           hold_sel_i,
  input  logic [WIDTH-1:0]               hold_data_i,
  output logic [NUM_WAYS-1:0]            out_valid_o,
  output logic [NUM_WAYS-1:0][WIDTH-1:0] data_o
);

  always_comb begin
    out_valid_o = '0;
    data_o      = '0;
    for (int k = 0; k < NUM_WAYS; k++) begin
      if (full_i && (hold_sel_i == sel_t'(k))) out_valid_o[k] = 1'b1;
      if ((ZERO_IDLE == 0) || out_valid_o[k]) data_o[k] = hold_data_i;
    end
  end

endmodule

// File: rtl/dmux8way16_reg.sv
// Registered 8-way demultiplexer: one word is held and presented on its
// destination channel until that channel accepts it.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : handshake/data bundle (slave side)
//
// state    | meaning
// ST_EMPTY | no word held, in_ready=1
// ST_FULL  | word pending on channel hold_sel_q
module dmux8way16_reg
  import dmux_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ZERO_IDLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  dmux8way16_reg_if.slave    bus
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  sel_t             hold_sel_q, hold_sel_d;
  sel_t             rr_ptr_q, rr_ptr_d;

  logic full, drain, accept;
  logic [NUM_WAYS-1:0][WIDTH-1:0] data_fan;

  assign full   = (state_q == ST_FULL);
  assign drain  = full && bus.out_ready[hold_sel_q];
  // Ready passes straight through from the selected out_ready so a word can
  // drain and be replaced on the same edge.
  assign bus.in_ready = !full || drain;
  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      hold_data_d = bus.in_data;
      hold_sel_d  = bus.rr_mode ? rr_ptr_q : bus.in_sel;
      if (bus.rr_mode) rr_ptr_d = rr_ptr_q + sel_t'(1);
    end
  end

  dmux8way16_comb #(
    .WIDTH     (WIDTH),
    .ZERO_IDLE (ZERO_IDLE)
  ) u_comb (
    .full_i      (full),
    .hold_sel_i  (hold_sel_q),
    .hold_data_i (hold_data_q),
    .out_valid_o (bus.out_valid),
    .data_o      (data_fan)
  );

  assign bus.a      = data_fan[0];
  assign bus.b      = data_fan[1];
  assign bus.c      = data_fan[2];
  assign bus.d      = data_fan[3];
  assign bus.e      = data_fan[4];
  assign bus.f      = data_fan[5];
  assign bus.g      = data_fan[6];
  assign bus.h      = data_fan[7];
  assign bus.rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_dmux8way16_reg.sv
// Bench for dmux8way16_reg: a reference model at negedge predicts accepts
// and routing into a queue; the pending front is compared against the DUT
// outputs every cycle and popped on drain. Directed steps add point checks.
module tb_dmux8way16_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmux8way16_reg_if #(.WIDTH(16)) bus ();

  dmux8way16_reg #(.WIDTH(16), .ZERO_IDLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned dest;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int unsigned model_ptr = 0;
  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] chan(int k);
    case (k)
      0: return bus.a;
      1: return bus.b;
      2: return bus.c;
      3: return bus.d;
      4: return bus.e;
      5: return bus.f;
      6: return bus.g;
      default: return bus.h;
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_ptr = 0;
    end else begin
      logic [7:0] exp_ov;
      logic exp_rdy;
      int bad;
      exp_ov = 8'h00;
      if (exp_q.size() != 0) exp_ov[exp_q[0].dest] = 1'b1;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        logic [15:0] e;
        e = exp_ov[k] ? exp_q[0].data : 16'h0000;
        if (chan(k) !== e) begin
          bad++;
          $display("FAIL chan_%0d: got 0x%0h expected 0x%0h at %0t", k, chan(k), e, $time);
        end
      end
      tests++;
      if (bad != 0) fails++;
      exp_rdy = (exp_q.size() == 0) || bus.out_ready[exp_q[0].dest];
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("rr_ptr", 32'(bus.rr_ptr), model_ptr);
      if (exp_q.size() != 0 && bus.out_ready[exp_q[0].dest]) void'(exp_q.pop_front());
      if (bus.in_valid && exp_rdy) begin
        exp_t t;
        t.data = bus.in_data;
        if (bus.rr_mode) begin
          t.dest = model_ptr;
          model_ptr = (model_ptr + 1) % 8;
        end else begin
          t.dest = int'(bus.in_sel);
        end
        exp_q.push_back(t);
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rr_mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.in_sel = '0; bus.out_ready = 8'h00;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_rr_ptr", 32'(bus.rr_ptr), 32'h0);
    cyc(); rst_n = 1'b1; cyc();

    // Basic route
    bus.out_ready = 8'hFF; bus.in_valid = 1'b1; bus.in_data = 16'hBEEF; bus.in_sel = 3'd3;
    cyc();
    bus.in_valid = 1'b0;
    chk("basic_out_valid", 32'(bus.out_valid), 32'h08);
    chk("basic_d", 32'(bus.d), 32'hBEEF);
    chk("basic_a", 32'(bus.a), 32'h0);
    cyc();
    chk("basic_drained", 32'(bus.out_valid), 32'h0);

    // Backpressure on channel 6
    bus.out_ready = 8'hBF; bus.in_valid = 1'b1; bus.in_data = 16'h1111; bus.in_sel = 3'd6;
    cyc();
    bus.in_data = 16'h2222; bus.in_sel = 3'd2;
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_g", 32'(bus.g), 32'h1111);
      chk("bp_out_valid", 32'(bus.out_valid), 32'h40);
      cyc();
    end
    bus.out_ready = 8'hFF; #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("bp_next_c", 32'(bus.c), 32'h2222);
    chk("bp_next_valid", 32'(bus.out_valid), 32'h04);
    bus.in_valid = 1'b0;
    cyc();

    // Wrong-channel ready
    bus.out_ready = 8'hFB; bus.in_valid = 1'b1; bus.in_data = 16'h3333; bus.in_sel = 3'd2;
    cyc();
    bus.in_valid = 1'b0;
    cyc(3);
    chk("wrongch_pending", 32'(bus.out_valid), 32'h04);
    chk("wrongch_c", 32'(bus.c), 32'h3333);
    bus.out_ready = 8'hFF;
    cyc();

    // Round-robin, 10 back-to-back words
    bus.rr_mode = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 16'(i); bus.in_sel = 3'(7 - (i % 8));
      #1;
      chk("rr_throughput", 32'(bus.in_ready), 32'h1);
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("rr_ptr_end", 32'(bus.rr_ptr), 32'h2);
    cyc();

    // Mode switch
    bus.in_valid = 1'b1; bus.in_data = 16'h0A0A;
    cyc(2);
    bus.rr_mode = 1'b0; bus.in_sel = 3'd1; bus.in_data = 16'h4444;
    cyc();
    bus.in_valid = 1'b0;
    chk("ms_b", 32'(bus.b), 32'h4444);
    chk("ms_ptr_hold", 32'(bus.rr_ptr), 32'h4);
    cyc();
    bus.rr_mode = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h5555; bus.in_sel = 3'd0;
    cyc();
    bus.in_valid = 1'b0;
    chk("ms_e", 32'(bus.e), 32'h5555);
    chk("ms_valid", 32'(bus.out_valid), 32'h10);
    cyc();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.rr_mode   = ($urandom_range(0, 3) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 16'($urandom);
      bus.in_sel    = 3'($urandom);
      bus.out_ready = 8'($urandom) | 8'($urandom);
      cyc();
    end
    bus.in_valid = 1'b0; bus.out_ready = 8'hFF;
    cyc(2);

    // Asynchronous reset while holding a word for channel 5
    bus.rr_mode = 1'b0; bus.out_ready = 8'h00;
    bus.in_valid = 1'b1; bus.in_data = 16'hABCD; bus.in_sel = 3'd5;
    cyc();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_f", 32'(bus.f), 32'h0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("arst_rr_ptr", 32'(bus.rr_ptr), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_valid", 32'(bus.out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
